// File: rtl/matrix_loader_if.sv
// Handshake and result bus between an element source and the matrix loader.
// The master side streams elements; the slave side (the loader) returns packed matrices.
interface matrix_loader_if;
    logic              start;
    logic              abort;
    logic [1:0]        matrix_size;
    logic signed [7:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [199:0]      matrix_A;
    logic [199:0]      matrix_B;
    logic [1:0]        size_out;
    logic              load_done;
    logic              busy;

    modport master (
        output start, abort, matrix_size, data_in, data_valid,
        input  data_ready, matrix_A, matrix_B, size_out, load_done, busy
    );

    modport slave (
        input  start, abort, matrix_size, data_in, data_valid,
        output data_ready, matrix_A, matrix_B, size_out, load_done, busy
    );
endinterface

// File: rtl/matrix_loader.sv
// Loads two square matrices (2x2..5x5, 8-bit elements, row-major) from a
// valid/ready stream into packed 25-element operand buses for a downstream subtractor.
module matrix_loader (
    input  logic            clk,
    input  logic            reset,
    matrix_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [4:0]     index_r;
    logic [199:0]   matrix_a_r;
    logic [199:0]   matrix_b_r;
    logic [1:0]     size_r;
    logic           data_ready_r;
    logic           busy_r;
    logic           load_done_r;

    logic           loading_s;
    logic           abort_s;
    logic           xfer_s;
    logic           last_s;
    logic [7:0]     offset_s;

    function automatic logic [4:0] elem_count(input logic [1:0] size);
        case (size)
            2'b00:   return 5'd4;
            2'b01:   return 5'd9;
            2'b10:   return 5'd16;
            2'b11:   return 5'd25;
            default: return 5'd4;
        endcase
    endfunction

    // Transfer qualification; abort wins over a simultaneous element.
    always_comb begin
        loading_s = (state_r == LOAD_A) || (state_r == LOAD_B);
        abort_s   = loading_s && bus.abort;
        xfer_s    = loading_s && bus.data_valid && !bus.abort;
        last_s    = (index_r == (elem_count(size_r) - 5'd1));
        offset_s  = {index_r, 3'b000};
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    next_state_s = LOAD_A;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD_A: begin
                if (abort_s) begin
                    next_state_s = IDLE;
                end else if (xfer_s && last_s) begin
                    next_state_s = LOAD_B;
                end else begin
                    next_state_s = LOAD_A;
                end
            end
            LOAD_B: begin
                if (abort_s) begin
                    next_state_s = IDLE;
                end else if (xfer_s && last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = LOAD_B;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; status outputs are registered from the next state so
    // they line up with the state they describe and never depend on data_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            data_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            load_done_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            data_ready_r <= (next_state_s == LOAD_A) || (next_state_s == LOAD_B);
            busy_r       <= (next_state_s != IDLE);
            load_done_r  <= (next_state_s == DONE);
        end
    end

    // Element index, operand storage and latched size.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_r    <= 5'd0;
            matrix_a_r <= 200'd0;
            matrix_b_r <= 200'd0;
            size_r     <= 2'b00;
        end else if ((state_r == IDLE) && bus.start) begin
            size_r     <= bus.matrix_size;
            index_r    <= 5'd0;
            matrix_a_r <= 200'd0;
            matrix_b_r <= 200'd0;
        end else if (abort_s) begin
            index_r    <= 5'd0;
            matrix_a_r <= 200'd0;
            matrix_b_r <= 200'd0;
        end else if (xfer_s) begin
            if (state_r == LOAD_A) begin
                matrix_a_r[offset_s +: 8] <= bus.data_in;
            end else begin
                matrix_b_r[offset_s +: 8] <= bus.data_in;
            end
            index_r <= last_s ? 5'd0 : (index_r + 5'd1);
        end
    end

    assign bus.data_ready = data_ready_r;
    assign bus.busy       = busy_r;
    assign bus.load_done  = load_done_r;
    assign bus.matrix_A   = matrix_a_r;
    assign bus.matrix_B   = matrix_b_r;
    assign bus.size_out   = size_r;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader.
module tb_matrix_loader;

    logic clk;
    logic reset;
    int   total_count;
    int   pass_count;
    int   pulses;
    logic [199:0] exp_a;
    logic [199:0] exp_b;
    logic [7:0]   v;

    matrix_loader_if bus ();

    matrix_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        total_count = total_count + 1;
        if (got === exp) begin
            pass_count = pass_count + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] size);
        bus.matrix_size = size;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    initial begin
        total_count     = 0;
        pass_count      = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.matrix_size = 2'b00;
        bus.data_in     = 8'h00;
        bus.data_valid  = 1'b0;
        tick();
        tick();
        check("rst_ready", {199'd0, bus.data_ready}, 200'd0);
        check("rst_busy",  {199'd0, bus.busy},       200'd0);
        check("rst_done",  {199'd0, bus.load_done},  200'd0);
        check("rst_a",     bus.matrix_A,             200'd0);
        check("rst_b",     bus.matrix_B,             200'd0);
        check("rst_size",  {198'd0, bus.size_out},   200'd0);
        reset = 1'b0;
        tick();

        // 2x2 streaming with valid held high
        do_start(2'b00);
        check("2x2_busy",  {199'd0, bus.busy},       200'd1);
        check("2x2_ready", {199'd0, bus.data_ready}, 200'd1);
        for (int k = 0; k < 4; k++) send(8'(k + 1));
        check("2x2_a_part", bus.matrix_A, 200'h04030201);
        for (int k = 0; k < 4; k++) send(8'(k + 5));
        check("2x2_done", {199'd0, bus.load_done}, 200'd1);
        check("2x2_a",    bus.matrix_A, 200'h04030201);
        check("2x2_b",    bus.matrix_B, 200'h08070605);
        check("2x2_size", {198'd0, bus.size_out}, 200'd0);
        check("2x2_ready_done", {199'd0, bus.data_ready}, 200'd0);
        tick();
        check("2x2_done_clr", {199'd0, bus.load_done}, 200'd0);
        check("2x2_idle",     {199'd0, bus.busy},      200'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("idle_abort_a", bus.matrix_A, 200'h04030201);
        check("idle_abort_b", bus.matrix_B, 200'h08070605);

        // 5x5 with valid gaps and full signed range
        exp_a  = 200'd0;
        exp_b  = 200'd0;
        pulses = 0;
        do_start(2'b11);
        for (int k = 0; k < 50; k++) begin
            if ((k % 4) == 2) begin
                bus.data_in = 8'h55;
                tick();
                check("5x5_busy_gap", {199'd0, bus.busy}, 200'd1);
                if (bus.load_done) pulses = pulses + 1;
            end
            if (k < 25) begin
                v = (k == 24) ? 8'h7F : 8'(k * 19 - 128);
                exp_a[k*8 +: 8] = v;
            end else begin
                v = 8'(127 - (k - 25) * 23);
                exp_b[(k-25)*8 +: 8] = v;
            end
            send(v);
            check("5x5_busy", {199'd0, bus.busy}, 200'd1);
            if (bus.load_done) pulses = pulses + 1;
        end
        tick();
        if (bus.load_done) pulses = pulses + 1;
        check("5x5_pulses", 200'(pulses), 200'd1);
        check("5x5_a", bus.matrix_A, exp_a);
        check("5x5_b", bus.matrix_B, exp_b);
        check("5x5_size", {198'd0, bus.size_out}, 200'd3);

        // abort after 5 of 9 A elements, abort colliding with a valid element
        do_start(2'b01);
        for (int k = 0; k < 5; k++) send(8'hA0 + 8'(k));
        bus.abort      = 1'b1;
        bus.data_in    = 8'hEE;
        bus.data_valid = 1'b1;
        tick();
        bus.abort      = 1'b0;
        bus.data_valid = 1'b0;
        check("abort_busy", {199'd0, bus.busy},       200'd0);
        check("abort_done", {199'd0, bus.load_done},  200'd0);
        check("abort_a",    bus.matrix_A,             200'd0);
        check("abort_b",    bus.matrix_B,             200'd0);
        tick();
        check("abort_done2", {199'd0, bus.load_done}, 200'd0);
        exp_a = 200'd0;
        exp_b = 200'd0;
        do_start(2'b01);
        for (int k = 0; k < 9; k++) begin
            exp_a[k*8 +: 8] = 8'(k + 16);
            send(8'(k + 16));
        end
        for (int k = 0; k < 9; k++) begin
            exp_b[k*8 +: 8] = 8'(8'hF7 - k);
            send(8'(8'hF7 - k));
        end
        check("3x3_done", {199'd0, bus.load_done}, 200'd1);
        check("3x3_a",    bus.matrix_A, exp_a);
        check("3x3_b",    bus.matrix_B, exp_b);
        tick();

        // reset during LOAD_B of a 4x4 load, with start asserted alongside
        do_start(2'b10);
        for (int k = 0; k < 16; k++) send(8'(k));
        for (int k = 0; k < 3; k++) send(8'h40);
        check("4x4_in_b", {199'd0, bus.data_ready}, 200'd1);
        reset           = 1'b1;
        bus.start       = 1'b1;
        bus.matrix_size = 2'b11;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("mid_rst_busy",  {199'd0, bus.busy},       200'd0);
        check("mid_rst_ready", {199'd0, bus.data_ready}, 200'd0);
        check("mid_rst_a",     bus.matrix_A,             200'd0);
        check("mid_rst_b",     bus.matrix_B,             200'd0);
        check("mid_rst_size",  {198'd0, bus.size_out},   200'd0);
        tick();
        check("rst_start_ign", {199'd0, bus.busy},      200'd0);
        check("rst_no_done",   {199'd0, bus.load_done}, 200'd0);

        // start and size change during LOAD_A are ignored
        do_start(2'b00);
        send(8'h11);
        send(8'h22);
        bus.start       = 1'b1;
        bus.matrix_size = 2'b11;
        tick();
        bus.start = 1'b0;
        check("ign_size", {198'd0, bus.size_out}, 200'd0);
        check("ign_a",    bus.matrix_A, 200'h2211);
        send(8'h33);
        send(8'h44);
        send(8'h81);
        send(8'h82);
        send(8'h83);
        send(8'h84);
        check("ign_done", {199'd0, bus.load_done}, 200'd1);
        check("ign_a2",   bus.matrix_A, 200'h44332211);
        check("ign_b",    bus.matrix_B, 200'h84838281);

        // back-to-back: start in the IDLE cycle right after load_done
        tick();
        check("b2b_idle", {199'd0, bus.busy}, 200'd0);
        bus.matrix_size = 2'b01;
        bus.start       = 1'b1;
        #2;
        check("b2b_hold_a", bus.matrix_A, 200'h44332211);
        check("b2b_hold_b", bus.matrix_B, 200'h84838281);
        tick();
        bus.start = 1'b0;
        check("b2b_busy", {199'd0, bus.busy},     200'd1);
        check("b2b_a",    bus.matrix_A,           200'd0);
        check("b2b_b",    bus.matrix_B,           200'd0);
        check("b2b_size", {198'd0, bus.size_out}, 200'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("b2b_abort", {199'd0, bus.busy}, 200'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The block SHALL have no parameters; element width is fixed at 8 bits and the matrix buses at 200 bits (25 elements).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a load of A then B; sampled only in IDLE.
REQ-005 abort  input  1  cancel a load in progress; return to IDLE.
REQ-006 matrix_size  input  2  00=2x2, 01=3x3, 10=4x4, 11=5x5; latched on accepted start.
REQ-007 data_in  input  8  signed element, two's complement.
REQ-008 data_valid  input  1  data_in holds a valid element.
REQ-009 data_ready  output  1  block accepts an element this cycle.
REQ-010 matrix_A  output  200  packed operand A; element k at bits [k*8 +: 8].
REQ-011 matrix_B  output  200  packed operand B; same packing.
REQ-012 size_out  output  2  latched matrix_size for the downstream subtractor.
REQ-013 load_done  output  1  one-cycle pulse when A and B are complete.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Element count N SHALL be 4/9/16/25 for latched size 00/01/10/11; elements SHALL arrive row-major, index k = row*n + col, k = 0..N-1.
REQ-016 FSM states SHALL be IDLE, LOAD_A, LOAD_B, DONE, held in registers.
REQ-017 IDLE with start=1 SHALL latch matrix_size into size_out, clear matrix_A, matrix_B and the 5-bit index to 0, and go to LOAD_A on the next edge.
REQ-018 data_ready SHALL be 1 exactly in LOAD_A and LOAD_B, driven from state only (no combinational path from data_valid).
REQ-019 A transfer SHALL occur when data_valid=1 and data_ready=1; data_in SHALL be written to element [index] of the matrix selected by state, and index SHALL increment.
REQ-020 A transfer at index N-1 in LOAD_A SHALL reset index to 0 and move to LOAD_B; a transfer at index N-1 in LOAD_B SHALL move to DONE.
REQ-021 Cycles with data_valid=0 SHALL leave state, index and matrices unchanged (stalls of any length).
REQ-022 DONE SHALL assert load_done for exactly one cycle and return to IDLE on the next edge; latency from the last B transfer edge to load_done high is one cycle.
REQ-023 Elements k >= N SHALL remain 0 in both matrices.
REQ-024 matrix_A, matrix_B and size_out SHALL hold their values in IDLE until the next accepted start.
REQ-025 start outside IDLE SHALL be ignored; matrix_size changes after latching SHALL have no effect.
REQ-026 abort=1 in LOAD_A or LOAD_B SHALL clear matrix_A, matrix_B and the index and go to IDLE without load_done; abort takes priority over a simultaneous transfer; abort in IDLE or DONE SHALL be ignored.
REQ-027 start and abort both 1 in IDLE SHALL be treated as start.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, index=0, matrix_A=0, matrix_B=0, size_out=00, load_done=0, busy=0, data_ready=0, regardless of state or other inputs.
REQ-029 reset SHALL take priority over start, abort and transfers; reset mid-load SHALL discard partial data with no load_done.

Verification
REQ-030 2x2: start, size=00, stream A=1,2,3,4 and B=5,6,7,8 with valid held high -> load_done pulses one cycle after the 8th transfer; matrix_A[31:0]=0x04030201, matrix_B[31:0]=0x08070605, upper bits 0, size_out=00.
REQ-031 5x5 with random valid gaps: 50 elements with values -128..127 -> every element placed at index k; busy is high throughout; load_done pulses exactly once.
REQ-032 Abort after 5 of 9 A elements (size=01) -> IDLE next cycle, both matrices 0, no load_done; a following 3x3 load completes normally.
REQ-033 Reset asserted during LOAD_B of a 4x4 load -> all outputs take their reset values next cycle; a start during the reset cycle is ignored.
REQ-034 start pulsed during LOAD_A, and matrix_size changed from 00 to 11 mid-load -> no effect; load completes after 4+4 transfers.
REQ-035 Back-to-back: start asserted in the cycle after load_done -> new load accepted; previous matrices hold until that start edge, then clear.
